// File: rtl/palette_dac_if.sv
// CPU-side palette bus: word address, write/read data, byte strobes, chip select and DTACK.
interface palette_dac_if;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;

  logic [ADDR_W-1:0] CA;
  logic [DATA_W-1:0] Din;
  logic [DATA_W-1:0] Dout;
  logic              UDSn;
  logic              LDSn;
  logic              PCSn;
  logic              RW;
  logic              DACKn;

  modport master (output CA, Din, UDSn, LDSn, PCSn, RW, input Dout, DACKn);
  modport slave  (input CA, Din, UDSn, LDSn, PCSn, RW, output Dout, DACKn);
endinterface

// File: rtl/palette_dac.sv
// Palette lookup and RGB output stage; pixel and CPU accesses share palette RAM in alternate ce_13m slots.
// Build option: define PALETTE_RGB555_EN for xRGB555 palette words (default is RGB444).
module palette_dac (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce_13m,
  input  logic         ce_pixel,
  palette_dac_if.slave cpu,
  output logic [11:0]  RA,
  input  logic [15:0]  RDin,
  output logic [15:0]  RDout,
  output logic         RWEUPn,
  output logic         RWELOn,
  input  logic [11:0]  IDX,
  input  logic         HBLn,
  input  logic         VBLn,
  output logic [7:0]   R,
  output logic [7:0]   G,
  output logic [7:0]   B,
  output logic         HBLOn,
  output logic         VBLOn
);

`ifdef PALETTE_RGB555_EN
  localparam int unsigned COL_W = 15;
`else
  localparam int unsigned COL_W = 12;
`endif

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACCESS, S_ACK} state_t;

  state_t           state_q, state_nxt;
  logic             start_c;
  logic             prev_cs;
  logic             cs_fall;
  logic             cpu_slot;
  logic             rd_q;
  logic             hbl_stg, vbl_stg;
  logic [COL_W-1:0] pix_word;
  logic [7:0]       r_exp, g_exp, b_exp;
  logic [15:0]      dout_q;
  logic             dackn_q;

  assign cpu_slot  = ~ce_pixel;
  assign cs_fall   = prev_cs & ~cpu.PCSn;
  assign RDout     = cpu.Din;
  assign cpu.Dout  = dout_q;
  assign cpu.DACKn = dackn_q;

  // Colour expansion: replicate high bits into the low bits so full-scale maps to 8'hFF.
  always_comb begin
`ifdef PALETTE_RGB555_EN
    r_exp = {pix_word[14:10], pix_word[14:12]};
    g_exp = {pix_word[9:5],   pix_word[9:7]};
    b_exp = {pix_word[4:0],   pix_word[4:2]};
`else
    r_exp = {2{pix_word[11:8]}};
    g_exp = {2{pix_word[7:4]}};
    b_exp = {2{pix_word[3:0]}};
`endif
  end

  // CPU request sequencing state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_nxt;
  end

  // A fall seen on a CPU-slot pulse starts immediately; otherwise it waits one pulse in PEND.
  always_comb begin
    state_nxt = state_q;
    start_c   = 1'b0;
    if (ce_13m) begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            if (cpu_slot) begin
              state_nxt = S_ACCESS;
              start_c   = 1'b1;
            end else begin
              state_nxt = S_PEND;
            end
          end
        end
        S_PEND: begin
          if (cpu.PCSn) begin
            state_nxt = S_IDLE;
          end else if (cpu_slot) begin
            state_nxt = S_ACCESS;
            start_c   = 1'b1;
          end
        end
        S_ACCESS: state_nxt = cpu.PCSn ? S_IDLE : S_ACK;
        S_ACK:    if (cpu.PCSn) state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Slot datapath: pixel slot drives IDX to RAM and updates the pixel outputs; CPU slot captures the colour word.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_cs  <= 1'b1;
      dackn_q  <= 1'b1;
      RWEUPn   <= 1'b1;
      RWELOn   <= 1'b1;
      RA       <= 12'd0;
      dout_q   <= 16'd0;
      rd_q     <= 1'b0;
      hbl_stg  <= 1'b0;
      vbl_stg  <= 1'b0;
      pix_word <= COL_W'(0);
      R        <= 8'd0;
      G        <= 8'd0;
      B        <= 8'd0;
      HBLOn    <= 1'b0;
      VBLOn    <= 1'b0;
    end else if (ce_13m) begin
      prev_cs <= cpu.PCSn;
      dackn_q <= (state_nxt != S_ACK);
      RWEUPn  <= 1'b1;
      RWELOn  <= 1'b1;
      if (ce_pixel) begin
        RA      <= IDX;
        hbl_stg <= HBLn;
        vbl_stg <= VBLn;
        HBLOn   <= hbl_stg;
        VBLOn   <= vbl_stg;
        R       <= (hbl_stg & vbl_stg) ? r_exp : 8'd0;
        G       <= (hbl_stg & vbl_stg) ? g_exp : 8'd0;
        B       <= (hbl_stg & vbl_stg) ? b_exp : 8'd0;
        if (state_q == S_ACCESS && rd_q) dout_q <= RDin;
      end else begin
        pix_word <= RDin[COL_W-1:0];
        if (start_c) begin
          RA   <= cpu.CA;
          rd_q <= cpu.RW;
          if (!cpu.RW) begin
            RWEUPn <= cpu.UDSn;
            RWELOn <= cpu.LDSn;
          end
        end
      end
    end
  end

endmodule
